// File: rtl/piggy_coin_ledger.sv
// piggy_coin_ledger: synchronizes and debounces the coin sensor, detects
// withdraw-button edges, and keeps a saturating savings balance with
// registered one-cycle status pulses for the display/output stage.
module piggy_coin_ledger #(
  parameter int BAL_W        = 12,
  parameter int DEBOUNCE_CYC = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             coin_in,
  input  logic [1:0]       coin_type,
  input  logic             wd_req,
  input  logic [7:0]       wd_amt,
  output logic [BAL_W-1:0] balance,
  output logic             coin_ack,
  output logic             wd_ok,
  output logic             wd_err,
  output logic             full
);

  // Arithmetic runs one bit wider than the balance so overflow is visible
  // before saturation. wd_amt is zero-extended into this width, so BAL_W
  // is expected to be at least 8.
  localparam int                BW1     = BAL_W + 1;
  localparam logic [BW1-1:0]    MAX_BAL = {1'b0, {BAL_W{1'b1}}};
  localparam logic [CNT_W-1:0]  DEB     = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUAL_HI = 2'd1,
    ST_WAIT_LO = 2'd2
  } coin_st_e;

  // Synchronizer and edge-detect flops
  logic coin_s1_q, coin_s2_q;
  logic wd_s1_q, wd_s2_q, wd_prev_q;

  // Coin FSM
  coin_st_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             credit_s;

  // Ledger
  logic [BAL_W-1:0] balance_q, balance_d;
  logic             full_q, full_d;
  logic             coin_ack_q, coin_ack_d;
  logic             wd_ok_q, wd_ok_d;
  logic             wd_err_q, wd_err_d;
  logic             wd_rise_s, wd_accept_s, wd_reject_s;
  logic [BW1-1:0]   bal_ext_s, amt_ext_s, coin_val_s, sum_s;

  assign cnt_inc_s = cnt_q + CNT_ONE;
  assign wd_rise_s = wd_s2_q & ~wd_prev_q;

  // Two-flop synchronizers plus withdraw edge register; these track even when ena=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_s1_q <= 1'b0;
      coin_s2_q <= 1'b0;
      wd_s1_q   <= 1'b0;
      wd_s2_q   <= 1'b0;
      wd_prev_q <= 1'b0;
    end else begin
      coin_s1_q <= coin_in;
      coin_s2_q <= coin_s1_q;
      wd_s1_q   <= wd_req;
      wd_s2_q   <= wd_s1_q;
      wd_prev_q <= wd_s2_q;
    end
  end

  // Coin FSM state and debounce counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Coin FSM next state: qualify a high level, then require a qualified low before re-arming
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (coin_s2_q) begin
            if (DEB == CNT_ONE) begin
              state_d = ST_WAIT_LO;
              cnt_d   = '0;
            end else begin
              state_d = ST_QUAL_HI;
              cnt_d   = CNT_ONE;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = cnt_q;
          end
        end
        ST_QUAL_HI: begin
          if (coin_s2_q) begin
            if (cnt_inc_s == DEB) begin
              state_d = ST_WAIT_LO;
              cnt_d   = '0;
            end else begin
              state_d = ST_QUAL_HI;
              cnt_d   = cnt_inc_s;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LO: begin
          if (!coin_s2_q) begin
            if (cnt_inc_s == DEB) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = ST_WAIT_LO;
              cnt_d   = cnt_inc_s;
            end
          end else begin
            state_d = ST_WAIT_LO;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  // Coin FSM output: credit on the edge where the high level becomes qualified
  always_comb begin
    credit_s = 1'b0;
    if (ena && coin_s2_q) begin
      case (state_q)
        ST_IDLE:    credit_s = (DEB == CNT_ONE);
        ST_QUAL_HI: credit_s = (cnt_inc_s == DEB);
        ST_WAIT_LO: credit_s = 1'b0;
        default:    credit_s = 1'b0;
      endcase
    end else begin
      credit_s = 1'b0;
    end
  end

  // Ledger update: withdraw is checked against the pre-credit balance, result saturates
  always_comb begin
    bal_ext_s   = {1'b0, balance_q};
    amt_ext_s   = BW1'(wd_amt);
    wd_accept_s = 1'b0;
    wd_reject_s = 1'b0;
    case (coin_type)
      2'b00:   coin_val_s = BW1'(1);
      2'b01:   coin_val_s = BW1'(2);
      2'b10:   coin_val_s = BW1'(5);
      2'b11:   coin_val_s = BW1'(10);
      default: coin_val_s = BW1'(0);
    endcase
    if (ena && wd_rise_s) begin
      if ((wd_amt != 8'd0) && (amt_ext_s <= bal_ext_s)) begin
        wd_accept_s = 1'b1;
      end else begin
        wd_reject_s = 1'b1;
      end
    end else begin
      wd_accept_s = 1'b0;
      wd_reject_s = 1'b0;
    end
    sum_s = bal_ext_s
          - (wd_accept_s ? amt_ext_s  : BW1'(0))
          + (credit_s    ? coin_val_s : BW1'(0));
    if (sum_s > MAX_BAL) begin
      balance_d = MAX_BAL[BAL_W-1:0];
    end else begin
      balance_d = sum_s[BAL_W-1:0];
    end
    full_d     = (balance_d == MAX_BAL[BAL_W-1:0]);
    coin_ack_d = credit_s;
    wd_ok_d    = wd_accept_s;
    wd_err_d   = wd_reject_s;
  end

  // Registered ledger outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      balance_q  <= '0;
      full_q     <= 1'b0;
      coin_ack_q <= 1'b0;
      wd_ok_q    <= 1'b0;
      wd_err_q   <= 1'b0;
    end else begin
      balance_q  <= balance_d;
      full_q     <= full_d;
      coin_ack_q <= coin_ack_d;
      wd_ok_q    <= wd_ok_d;
      wd_err_q   <= wd_err_d;
    end
  end

  assign balance  = balance_q;
  assign full     = full_q;
  assign coin_ack = coin_ack_q;
  assign wd_ok    = wd_ok_q;
  assign wd_err   = wd_err_q;

endmodule

// File: tb/tb_piggy_coin_ledger.sv
// Self-checking bench for piggy_coin_ledger: directed scenarios plus random
// stimulus, every cycle compared against a window-based behavioural model.
module tb_piggy_coin_ledger;

  localparam int BAL_W = 12;
  localparam int DEB   = 4;
  localparam int MAXB  = (1 << BAL_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             ena = 1'b0;
  logic             coin_in = 1'b0;
  logic [1:0]       coin_type = 2'b00;
  logic             wd_req = 1'b0;
  logic [7:0]       wd_amt = 8'd0;
  logic [BAL_W-1:0] balance;
  logic             coin_ack, wd_ok, wd_err, full;

  piggy_coin_ledger #(.BAL_W(BAL_W), .DEBOUNCE_CYC(DEB), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .coin_in(coin_in), .coin_type(coin_type),
    .wd_req(wd_req), .wd_amt(wd_amt),
    .balance(balance), .coin_ack(coin_ack),
    .wd_ok(wd_ok), .wd_err(wd_err), .full(full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int  m_bal;
  bit  m_ack, m_ok, m_err;
  bit  c_pipe[2];
  bit  w_pipe[2];
  bit  w_prev;
  bit  hist[$];
  bit  armed;
  int  coin_val[4] = '{1, 2, 5, 10};

  // Observation bookkeeping for directed scenarios
  int cyc_idx, n_ack, n_ok, n_err, ack_idx, wd_idx;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bal = 0; m_ack = 0; m_ok = 0; m_err = 0;
    c_pipe[0] = 0; c_pipe[1] = 0;
    w_pipe[0] = 0; w_pipe[1] = 0;
    w_prev = 0;
    hist.delete();
    armed = 1;
  endtask

  // One clock edge of the model: a coin credits when the last DEB enabled
  // synchronized samples are all high and the sensor has been re-armed by
  // DEB consecutive lows since the previous credit.
  task automatic model_step();
    bit sc, sw, rise, all1, all0;
    int n1, nb, credit;
    sc = c_pipe[1]; c_pipe[1] = c_pipe[0]; c_pipe[0] = coin_in;
    sw = w_pipe[1]; w_pipe[1] = w_pipe[0]; w_pipe[0] = wd_req;
    rise = sw && !w_prev;
    w_prev = sw;
    m_ack = 0; m_ok = 0; m_err = 0;
    if (ena) begin
      hist.push_back(sc);
      if (hist.size() > DEB) void'(hist.pop_front());
      n1 = 0;
      foreach (hist[k]) n1 += int'(hist[k]);
      all1 = (hist.size() == DEB) && (n1 == DEB);
      all0 = (hist.size() == DEB) && (n1 == 0);
      credit = 0;
      nb = m_bal;
      if (armed && all1) begin
        m_ack = 1; armed = 0; credit = coin_val[coin_type];
      end else if (!armed && all0) begin
        armed = 1;
      end
      if (rise) begin
        if (wd_amt != 0 && int'(wd_amt) <= m_bal) begin
          m_ok = 1; nb = nb - int'(wd_amt);
        end else begin
          m_err = 1;
        end
      end
      nb = nb + credit;
      if (nb > MAXB) nb = MAXB;
      m_bal = nb;
    end
  endtask

  task automatic clr_obs();
    cyc_idx = 0; n_ack = 0; n_ok = 0; n_err = 0; ack_idx = -1; wd_idx = -1;
  endtask

  // Drive inputs, take one edge, step the model and compare every output
  task automatic cyc(input logic c, input logic [1:0] t, input logic w,
                     input logic [7:0] a, input logic e);
    coin_in = c; coin_type = t; wd_req = w; wd_amt = a; ena = e;
    @(posedge clk);
    model_step();
    #1;
    check_eq("balance", 32'(balance), 32'(m_bal));
    check_eq("coin_ack", 32'(coin_ack), 32'(m_ack));
    check_eq("wd_ok", 32'(wd_ok), 32'(m_ok));
    check_eq("wd_err", 32'(wd_err), 32'(m_err));
    check_eq("full", 32'(full), 32'(m_bal == MAXB));
    if (coin_ack) begin n_ack++; if (ack_idx < 0) ack_idx = cyc_idx; end
    if (wd_ok) n_ok++;
    if (wd_err) n_err++;
    if ((wd_ok || wd_err) && wd_idx < 0) wd_idx = cyc_idx;
    cyc_idx++;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_balance", 32'(balance), 32'd0);
    check_eq("rst_coin_ack", 32'(coin_ack), 32'd0);
    check_eq("rst_wd_ok", 32'(wd_ok), 32'd0);
    check_eq("rst_wd_err", 32'(wd_err), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [1:0] t);
    for (int i = 0; i < 5; i++) cyc(1'b1, t, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, t, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic withdraw(input logic [7:0] a);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b1, a, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b0, a, 1'b1);
  endtask

  initial begin
    logic       rc, rw;
    logic [1:0] rt;
    logic [7:0] ra;
    model_reset();
    async_reset();

    // Held coin: exactly one credit, five edges after first sample
    clr_obs();
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'b10, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 2'b10, 1'b0, 8'd0, 1'b1);
    check_eq("hold_ack_idx", 32'(ack_idx), 32'd5);
    check_eq("hold_ack_cnt", 32'(n_ack), 32'd1);
    check_eq("hold_bal", 32'(balance), 32'd5);

    // Two-cycle glitch is rejected
    clr_obs();
    for (int i = 0; i < 2; i++) cyc(1'b1, 2'b11, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 2'b11, 1'b0, 8'd0, 1'b1);
    check_eq("glitch_ack_cnt", 32'(n_ack), 32'd0);
    check_eq("glitch_bal", 32'(balance), 32'd5);

    // Reach 20, then withdraw 7 / 50 / 0
    press(2'b11);
    press(2'b10);
    check_eq("bal20", 32'(balance), 32'd20);
    clr_obs();
    withdraw(8'd7);
    check_eq("wd7_idx", 32'(wd_idx), 32'd2);
    check_eq("wd7_ok_cnt", 32'(n_ok), 32'd1);
    check_eq("wd7_bal", 32'(balance), 32'd13);
    clr_obs();
    withdraw(8'd50);
    check_eq("wd50_err_cnt", 32'(n_err), 32'd1);
    check_eq("wd50_bal", 32'(balance), 32'd13);
    clr_obs();
    withdraw(8'd0);
    check_eq("wd0_err_cnt", 32'(n_err), 32'd1);
    check_eq("wd0_ok_cnt", 32'(n_ok), 32'd0);

    // Fill to 4090, saturate, withdraw out of saturation
    async_reset();
    for (int i = 0; i < 409; i++) press(2'b11);
    check_eq("fill_bal", 32'(balance), 32'd4090);
    check_eq("fill_full", 32'(full), 32'd0);
    clr_obs();
    press(2'b11);
    check_eq("sat_bal", 32'(balance), 32'd4095);
    check_eq("sat_full", 32'(full), 32'd1);
    check_eq("sat_ack_cnt", 32'(n_ack), 32'd1);
    withdraw(8'd95);
    check_eq("unsat_bal", 32'(balance), 32'd4000);
    check_eq("unsat_full", 32'(full), 32'd0);

    // Credit and withdraw on the same edge
    async_reset();
    press(2'b01);
    press(2'b00);
    check_eq("bal3", 32'(balance), 32'd3);
    for (int i = 0; i < 10; i++) begin
      cyc(i < 6, 2'b10, (i >= 3) && (i < 6), 8'd3, 1'b1);
      if (i == 5) begin
        check_eq("same_edge_ack", 32'(coin_ack), 32'd1);
        check_eq("same_edge_ok", 32'(wd_ok), 32'd1);
      end
    end
    check_eq("same_edge_bal", 32'(balance), 32'd5);

    // Reset in the middle of qualification with balance 42
    async_reset();
    for (int i = 0; i < 4; i++) press(2'b11);
    press(2'b01);
    check_eq("bal42", 32'(balance), 32'd42);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b11, 1'b0, 8'd0, 1'b1);
    async_reset();
    clr_obs();
    for (int i = 0; i < 8; i++) cyc(1'b1, 2'b11, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 2'b11, 1'b0, 8'd0, 1'b1);
    check_eq("post_rst_ack_idx", 32'(ack_idx), 32'd5);
    check_eq("post_rst_bal", 32'(balance), 32'd10);

    // Withdraw edge while disabled is discarded, no late pulse
    clr_obs();
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'b00, 1'b1, 8'd5, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b1, 8'd5, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b0, 8'd5, 1'b1);
    check_eq("ena0_wd_pulses", 32'(n_ok + n_err), 32'd0);
    check_eq("ena0_bal", 32'(balance), 32'd10);

    // Random phase against the model
    rc = 1'b0; rw = 1'b0; rt = 2'b00; ra = 8'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) rc = ~rc;
      if (!rc) rt = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rw = ~rw;
      if (!rw) ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      cyc(rc, rt, rw, ra, $urandom_range(0, 11) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
